// File: rtl/viterbi_pkg.sv
// Shared Viterbi tagger types: sentence/tag sizing, index types, backtrace state encoding.
// Used by the word counter, forward-pass and backtrace blocks (BACKTRACE_READY_EN does not affect it).
package viterbi_pkg;

  localparam int unsigned word_num     = 16;
  localparam int unsigned word_num_bit = 4;
  localparam int unsigned POS_num      = 11;
  localparam int unsigned POS_num_bit  = 4;

  typedef logic [word_num_bit-1:0] word_t;
  typedef logic [POS_num_bit-1:0]  tag_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } bt_state_t;

  // One point of the best path: a word and the tag chosen for it.
  typedef struct packed {
    word_t word;
    tag_t  tag;
  } bt_pair_t;

  function automatic logic tag_in_range(input tag_t t);
    return t < tag_t'(POS_num);
  endfunction

endpackage

// File: rtl/backtrace_control_if.sv
// Backpointer read port and tag output stream of the backtrace controller.
// BACKTRACE_READY_EN adds the tag_ready back-pressure signal from the tag sink.
interface backtrace_control_if;

  viterbi_pkg::word_t bp_rd_word;
  viterbi_pkg::tag_t  bp_rd_pos;
  viterbi_pkg::tag_t  bp_rd_data;
  logic               bp_rd_en;

  logic               tag_valid;
  viterbi_pkg::word_t tag_word;
  viterbi_pkg::tag_t  tag_pos;
`ifdef BACKTRACE_READY_EN
  logic               tag_ready;
`endif

  modport master (
    output bp_rd_en, bp_rd_word, bp_rd_pos,
    input  bp_rd_data,
`ifdef BACKTRACE_READY_EN
    input  tag_ready,
`endif
    output tag_valid, tag_word, tag_pos
  );

  modport slave (
    input  bp_rd_en, bp_rd_word, bp_rd_pos,
    output bp_rd_data,
`ifdef BACKTRACE_READY_EN
    output tag_ready,
`endif
    input  tag_valid, tag_word, tag_pos
  );

endinterface

// File: rtl/backtrace_control.sv
// Viterbi backward pass: walks the backpointer memory from the last word down to word 0,
// emitting one (word, tag) pair per word. BACKTRACE_READY_EN enables tag_ready stalling.
module backtrace_control
  import viterbi_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_backtrace_control,
  input  logic                 start_backtrace_control,
  input  word_t                last_word_in,
  input  tag_t                 final_tag_in,
  backtrace_control_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  bt_state_t state;
  bt_pair_t  cur;
  bt_pair_t  ld;
  logic      ld_rd;
  logic      load;
  logic      xfer;

  logic      tag_valid_q;
  word_t     tag_word_q;
  tag_t      tag_pos_q;
  logic      rd_en_q;
  word_t     rd_word_q;
  tag_t      rd_pos_q;

`ifdef BACKTRACE_READY_EN
  assign xfer         = bus.tag_ready;
  // A stalled EMIT keeps its read pending but must not strobe the memory.
  assign bus.bp_rd_en = rd_en_q & bus.tag_ready;
`else
  assign xfer         = 1'b1;
  assign bus.bp_rd_en = rd_en_q;
`endif

  assign bus.tag_valid  = tag_valid_q;
  assign bus.tag_word   = tag_word_q;
  assign bus.tag_pos    = tag_pos_q;
  assign bus.bp_rd_word = rd_word_q;
  assign bus.bp_rd_pos  = rd_pos_q;

  // Next point to emit: the sentence end on a start, or one word back along the backpointer.
  always_comb begin
    ld.word = last_word_in;
    ld.tag  = final_tag_in;
    if (state == WAIT) begin
      ld.word = cur.word - word_t'(1);
      ld.tag  = bus.bp_rd_data;
    end
  end

  assign ld_rd = tag_in_range(ld.tag) && (ld.word != '0);
  assign load  = (state == WAIT) ||
                 (((state == IDLE) || (state == DONE)) && start_backtrace_control);

  always_ff @(posedge clk or negedge reset_backtrace_control) begin
    if (!reset_backtrace_control) begin
      state       <= IDLE;
      cur         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      tag_valid_q <= 1'b0;
      tag_word_q  <= '0;
      tag_pos_q   <= '0;
      rd_en_q     <= 1'b0;
      rd_word_q   <= '0;
      rd_pos_q    <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        state       <= EMIT;
        cur         <= ld;
        busy        <= 1'b1;
        tag_valid_q <= 1'b1;
        tag_word_q  <= ld.word;
        tag_pos_q   <= ld.tag;
        rd_en_q     <= ld_rd;
        if (ld_rd) begin
          rd_word_q <= ld.word;
          rd_pos_q  <= ld.tag;
        end
        if (state != WAIT) err <= 1'b0;
      end else begin
        case (state)
          EMIT: begin
            if (xfer) begin
              tag_valid_q <= 1'b0;
              rd_en_q     <= 1'b0;
              // The walk ends at word 0, or early on a tag that cannot index the memory.
              if (!tag_in_range(cur.tag) || (cur.word == '0)) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                if (!tag_in_range(cur.tag)) err <= 1'b1;
              end else begin
                state <= WAIT;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_backtrace_control.sv
// Self-checking bench for backtrace_control: directed and random walks against a path model.
module tb_backtrace_control;
  import viterbi_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  start;
  word_t last_word_in;
  tag_t  final_tag_in;
  logic  busy, done, err;

  int n_vec = 0;
  int n_err = 0;

  backtrace_control_if bif();

  backtrace_control dut (
    .clk                     (clk),
    .reset_backtrace_control (rst_n),
    .start_backtrace_control (start),
    .last_word_in            (last_word_in),
    .final_tag_in            (final_tag_in),
    .bus                     (bif),
    .busy                    (busy),
    .done                    (done),
    .err                     (err)
  );

  always #5 clk = ~clk;

  tag_t mem [word_num][word_num];

  // Backpointer memory: registered read, data the cycle after the strobe.
  always @(posedge clk) begin
    if (bif.bp_rd_en) bif.bp_rd_data <= mem[bif.bp_rd_word][bif.bp_rd_pos];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic tag_t rand_tag();
    if ($urandom_range(0, 15) == 0) return tag_t'($urandom_range(11, 15));
    return tag_t'($urandom_range(0, 10));
  endfunction

  task automatic fill_mem();
    for (int w = 0; w < 16; w++)
      for (int t = 0; t < 16; t++)
        mem[w][t] = rand_tag();
  endtask

  task automatic start_walk(input int l, input int f);
    start        = 1'b1;
    last_word_in = word_t'(l);
    final_tag_in = tag_t'(f);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_tag_valid"}, 32'(bif.tag_valid), 0);
    check({pfx, "_tag_word"},  32'(bif.tag_word), 0);
    check({pfx, "_tag_pos"},   32'(bif.tag_pos), 0);
    check({pfx, "_rd_en"},     32'(bif.bp_rd_en), 0);
    check({pfx, "_rd_word"},   32'(bif.bp_rd_word), 0);
    check({pfx, "_rd_pos"},    32'(bif.bp_rd_pos), 0);
    check({pfx, "_busy"},      32'(busy), 0);
    check({pfx, "_done"},      32'(done), 0);
    check({pfx, "_err"},       32'(err), 0);
  endtask

  // Called at the negedge where start is driven; returns at the negedge of the done cycle.
  task automatic do_walk(input int l, input int f, input int ignore_at,
                         input bit chain, input int nl, input int nf, output bit bad);
    int ew[16];
    int et[16];
    bit rd[16];
    int n, w, t, ig, last_rw, last_rp;
    n = 0; w = l; t = f; bad = 0; last_rw = 0; last_rp = 0;
    for (int k = 0; k < 16; k++) begin
      ew[n] = w; et[n] = t; rd[n] = 0; n++;
      if (t >= 11) begin bad = 1; break; end
      if (w == 0) break;
      rd[n-1] = 1;
      t = int'(mem[w][t]);
      w = w - 1;
    end
    ig = ignore_at;
    if (ig < 0) ig = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2*n-1)) : 0;

    for (int c = 1; c <= 2*n; c++) begin
      bit vexp, rexp;
      int i;
      @(negedge clk);
      start = 1'b0;
      vexp = (c % 2 == 1) && (c <= 2*n-1);
      i = (c - 1) / 2;
      rexp = vexp && rd[i];
      check("tag_valid", 32'(bif.tag_valid), 32'(vexp));
      if (vexp) begin
        check("tag_word", 32'(bif.tag_word), ew[i]);
        check("tag_pos",  32'(bif.tag_pos),  et[i]);
      end
      check("bp_rd_en", 32'(bif.bp_rd_en), 32'(rexp));
      if (rexp) begin
        check("bp_rd_word", 32'(bif.bp_rd_word), ew[i]);
        check("bp_rd_pos",  32'(bif.bp_rd_pos),  et[i]);
        last_rw = ew[i];
        last_rp = et[i];
      end else if ((c % 2 == 0) && (c < 2*n)) begin
        check("bp_rd_word_hold", 32'(bif.bp_rd_word), last_rw);
        check("bp_rd_pos_hold",  32'(bif.bp_rd_pos),  last_rp);
      end
      check("busy", 32'(busy), 32'(c < 2*n));
      check("done", 32'(done), 32'(c == 2*n));
      check("err",  32'(err),  (c == 2*n) ? 32'(bad) : 0);
      if (c == ig) begin
        start        = 1'b1;
        last_word_in = word_t'($urandom_range(0, 15));
        final_tag_in = tag_t'($urandom_range(0, 15));
      end
      if ((c == 2*n) && chain) start_walk(nl, nf);
    end
  endtask

  task automatic idle_check(input bit exp_err);
    @(negedge clk);
    check("idle_tag_valid", 32'(bif.tag_valid), 0);
    check("idle_busy",      32'(busy), 0);
    check("idle_done",      32'(done), 0);
    check("idle_rd_en",     32'(bif.bp_rd_en), 0);
    check("idle_err",       32'(err), 32'(exp_err));
  endtask

  initial begin
    bit bad;
    int l, f, nl, nf;
    bit ch;
`ifdef BACKTRACE_READY_EN
    bif.tag_ready = 1'b1;
`endif
    rst_n = 1'b0; start = 1'b0; last_word_in = '0; final_tag_in = '0;
    fill_mem();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: four-word path.
    fill_mem();
    mem[3][5] = 4'd2; mem[2][2] = 4'd7; mem[1][7] = 4'd0;
    start_walk(3, 5);
    do_walk(3, 5, 0, 0, 0, 0, bad);
    idle_check(0);

    // Directed: single-word sentence.
    start_walk(0, 4);
    do_walk(0, 4, 0, 0, 0, 0, bad);
    idle_check(0);

    // Directed: full-length sentence, start while busy at cycle 9.
    for (int w = 0; w < 16; w++)
      for (int t = 0; t < 16; t++)
        mem[w][t] = 4'd1;
    start_walk(15, 10);
    do_walk(15, 10, 9, 0, 0, 0, bad);
    idle_check(0);

    // Directed: out-of-range backpointer ends the walk with err.
    fill_mem();
    mem[2][3] = 4'd12;
    start_walk(2, 3);
    do_walk(2, 3, 0, 0, 0, 0, bad);
    check("bad_bp_flag", 32'(bad), 1);
    idle_check(1);

    // Random walks, sometimes restarted in the done cycle.
    l = $urandom_range(0, 15);
    f = rand_tag();
    start_walk(l, f);
    for (int k = 0; k < 30; k++) begin
      nl = $urandom_range(0, 15);
      nf = rand_tag();
      ch = (k != 29) && ($urandom_range(0, 1) == 1);
      fill_mem();
      do_walk(l, f, -1, ch, nl, nf, bad);
      if (!ch) begin
        idle_check(bad);
        @(negedge clk);
        start_walk(nl, nf);
      end
      l = nl;
      f = nf;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    // Reset in the middle of a walk.
    fill_mem();
    start_walk(5, 2);
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_tag_valid", 32'(bif.tag_valid), 0);
    check("post_reset_busy",      32'(busy), 0);
    start_walk(5, 2);
    do_walk(5, 2, 0, 0, 0, 0, bad);
    idle_check(bad);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
